// File: rtl/hdc_classify_ctrl_if.sv
// hdc_classify_ctrl_if: datapath bundle between the classify sequencer and the
// n-gram encoder / associative-memory compare.
//   master (sequencer): drives enc_clear, enc_char, enc_valid, enc_last, cmp_start;
//                       receives enc_ready, cmp_done, cmp_label.
//   slave  (datapath):  the mirror image.
// CHAR_LENGTH must match the sequencer's CHAR_LENGTH.
interface hdc_classify_ctrl_if #(
  parameter int unsigned CHAR_LENGTH = 8
);
  logic                   enc_clear;
  logic [CHAR_LENGTH-1:0] enc_char;
  logic                   enc_valid;
  logic                   enc_last;
  logic                   enc_ready;
  logic                   cmp_start;
  logic                   cmp_done;
  logic [1:0]             cmp_label;

  modport master (
    output enc_clear, enc_char, enc_valid, enc_last, cmp_start,
    input  enc_ready, cmp_done, cmp_label
  );

  modport slave (
    input  enc_clear, enc_char, enc_valid, enc_last, cmp_start,
    output enc_ready, cmp_done, cmp_label
  );
endinterface

// File: rtl/hdc_classify_ctrl.sv
// hdc_classify_ctrl: sequencer for the hyperdimensional spam/ham classifier.
// Latches one message and its length on start, clears the encoder, streams the
// characters (MSB-first, char 0 in the top byte) one per handshake, triggers the
// similarity compare and returns the class label with a one-cycle done pulse.
//
// Ports:
//   clk, reset     clock (rising edge) and asynchronous active-low reset
//   start          classify request, sampled only while idle
//   msg, length    message buffer and character count (clamped to MESSAGE_LENGTH)
//   busy           high whenever the sequencer is not idle
//   done           one-cycle pulse, result valid
//   result         00 ham, 01 spam, 11 inconclusive; held until next accepted start
//   timeout        compare watchdog fired; sticky until next accepted start
//   dp             encoder/compare bundle (hdc_classify_ctrl_if.master)
//
// Optional feature: define HDC_TIMEOUT_EN to bound the compare wait to TIMEOUT
// cycles. Without it the wait is unbounded and timeout is tied low.
// All outputs come straight from flops.
module hdc_classify_ctrl #(
  parameter int unsigned MESSAGE_LENGTH = 200,
  parameter int unsigned CHAR_LENGTH    = 8,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg,
  input  logic [7:0]                          length,
  output logic                                busy,
  output logic                                done,
  output logic [1:0]                          result,
  output logic                                timeout,
  hdc_classify_ctrl_if.master                 dp
);

  localparam int unsigned MsgWidth = CHAR_LENGTH * MESSAGE_LENGTH;
  localparam int unsigned IdxWidth = $clog2(MESSAGE_LENGTH + 1);
  localparam int unsigned SelWidth = $clog2(MsgWidth);

  if (TIMEOUT < 1 || MESSAGE_LENGTH < 1) begin : g_param_check
    $error("hdc_classify_ctrl: TIMEOUT and MESSAGE_LENGTH must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle, StClear, StEncode, StCmp, StWait, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [MsgWidth-1:0]    msg_q, msg_d;
  logic [IdxWidth-1:0]    len_q, len_d;
  logic [IdxWidth-1:0]    idx_q, idx_d;
  logic [IdxWidth-1:0]    len_clamped;
  logic [SelWidth-1:0]    char_base;
  logic [1:0]             result_d;
  logic                   handshake;

  // Registered-output next values.
  logic                   busy_d, done_d, enc_clear_d, enc_valid_d, enc_last_d, cmp_start_d;
  logic [CHAR_LENGTH-1:0] enc_char_d;

`ifdef HDC_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(TIMEOUT + 1);
  logic [WdWidth-1:0]     wd_q, wd_d;
  logic                   timeout_q, timeout_d;
`endif

  assign len_clamped = (32'(length) > MESSAGE_LENGTH) ? IdxWidth'(MESSAGE_LENGTH)
                                                      : IdxWidth'(length);
  assign handshake   = dp.enc_valid & dp.enc_ready;

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    len_d    = len_q;
    idx_d    = idx_q;
    result_d = result;
`ifdef HDC_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          msg_d    = msg;
          len_d    = len_clamped;
          idx_d    = '0;
          result_d = 2'b11;
`ifdef HDC_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d  = StClear;
        end
      end
      StClear: begin
        idx_d   = '0;
        // Empty message: nothing to compare, report inconclusive.
        state_d = (len_q == '0) ? StDone : StEncode;
      end
      StEncode: begin
        if (handshake) begin
          idx_d = idx_q + 1'b1;
          if (dp.enc_last) state_d = StCmp;
        end
      end
      StCmp: begin
`ifdef HDC_TIMEOUT_EN
        wd_d = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        // cmp_done beats a simultaneous watchdog expiry.
        if (dp.cmp_done) begin
          result_d = dp.cmp_label;
          state_d  = StDone;
        end
`ifdef HDC_TIMEOUT_EN
        else if (wd_q == WdWidth'(TIMEOUT - 1)) begin
          result_d  = 2'b11;
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    enc_clear_d = (state_d == StClear);
    cmp_start_d = (state_d == StCmp);
    enc_valid_d = (state_d == StEncode);
    enc_last_d  = enc_valid_d && (idx_d == len_q - 1'b1);
    // Char i sits at msg[MsgWidth-1-CHAR_LENGTH*i -: CHAR_LENGTH].
    char_base   = SelWidth'((MESSAGE_LENGTH - 1 - 32'(idx_d)) * CHAR_LENGTH);
    enc_char_d  = enc_valid_d ? msg_q[char_base +: CHAR_LENGTH] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      msg_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      result       <= 2'b11;
      busy         <= 1'b0;
      done         <= 1'b0;
      dp.enc_clear <= 1'b0;
      dp.enc_valid <= 1'b0;
      dp.enc_last  <= 1'b0;
      dp.enc_char  <= '0;
      dp.cmp_start <= 1'b0;
`ifdef HDC_TIMEOUT_EN
      wd_q         <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      result       <= result_d;
      busy         <= busy_d;
      done         <= done_d;
      dp.enc_clear <= enc_clear_d;
      dp.enc_valid <= enc_valid_d;
      dp.enc_last  <= enc_last_d;
      dp.enc_char  <= enc_char_d;
      dp.cmp_start <= cmp_start_d;
`ifdef HDC_TIMEOUT_EN
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

`ifdef HDC_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hdc_classify_ctrl.sv
// Self-checking bench for hdc_classify_ctrl. Each transaction is predicted from
// the message bytes, the clamped length, the applied enc_ready pattern and the
// compare delay; observations are gathered cycle by cycle relative to the cycle
// in which start is driven (t=0).
module tb_hdc_classify_ctrl;
  localparam int unsigned ML  = 200;
  localparam int unsigned CL  = 8;
  localparam int unsigned TO  = 16;
  localparam int unsigned MW  = ML * CL;
  localparam int unsigned SEQ = 2048;

`ifdef HDC_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [MW-1:0] msg = '0;
  logic [7:0]    length = '0;
  logic          busy, done, timeout;
  logic [1:0]    result;

  hdc_classify_ctrl_if #(.CHAR_LENGTH(CL)) bus ();

  hdc_classify_ctrl #(
    .MESSAGE_LENGTH(ML),
    .CHAR_LENGTH   (CL),
    .TIMEOUT       (TO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .msg    (msg),
    .length (length),
    .busy   (busy),
    .done   (done),
    .result (result),
    .timeout(timeout),
    .dp     (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passed = 0;
  logic [7:0] bytes [ML];
  bit         rdy_seq [SEQ];
  int         prev_result = 3;
  bit         prev_to = 1'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int len_in);
    for (int i = 0; i < ML; i++) msg[MW-1-CL*i -: CL] = bytes[i];
    length = len_in[7:0];
  endtask

  // rmode: 0 ready always, 1 toggling 1,0,1,0.., 2 random.
  // cmp_delay: WAIT cycles before cmp_done (0 = first WAIT cycle), <0 = never.
  task automatic run_msg(input string name, input int len_in, input int rmode,
                         input int cmp_delay, input int label, input bit noise);
    int L, E, ones, exp_lat, exp_res;
    bit exp_to;
    int done_t, done_res, hs, clear_cnt, clear_t, cs_cnt, cs_t, busy_cnt;
    int char_err, last_err, stab_err;
    bit done_to, stalled;
    logic [7:0] held;
    logic [7:0] saved [ML];

    L = (len_in > ML) ? ML : len_in;
    for (int i = 0; i < ML; i++) saved[i] = bytes[i];
    for (int i = 0; i < SEQ; i++)
      rdy_seq[i] = (rmode == 0 || i >= 1500) ? 1'b1 :
                   (rmode == 1) ? (i % 2 == 0) : bit'($urandom_range(0, 1));
    ones = 0;
    E = 0;
    while (ones < L) begin
      if (rdy_seq[E]) ones++;
      E++;
    end
    if (L == 0) begin
      exp_lat = 2; exp_res = 3; exp_to = 1'b0;
    end else if (cmp_delay >= 0 && (!ToEn || cmp_delay < TO)) begin
      exp_lat = E + cmp_delay + 4; exp_res = label; exp_to = 1'b0;
    end else begin
      exp_lat = E + TO + 3; exp_res = 3; exp_to = 1'b1;
    end

    done_t = -1; done_res = -1; done_to = 1'b0; hs = 0; clear_cnt = 0; clear_t = -1;
    cs_cnt = 0; cs_t = -1; busy_cnt = 0; char_err = 0; last_err = 0; stab_err = 0;
    stalled = 1'b0; held = '0;

    tick();
    for (int t = 0; t <= exp_lat + int'(TO) + 8 && done_t < 0; t++) begin
      if (t > 0) tick();
      start = (t == 0) || (noise && $urandom_range(0, 3) == 0);
      if (t == 0) set_msg(len_in);
      else if (noise) begin
        for (int w = 0; w < MW / 32; w++) msg[w*32 +: 32] = $urandom;
        length = 8'($urandom);
      end
      bus.enc_ready = (t >= 2 && t - 2 < SEQ) ? rdy_seq[t-2] : 1'b1;
      bus.cmp_done  = (L > 0 && cmp_delay >= 0 && t == 3 + E + cmp_delay) ||
                      (noise && (t == 1 || t == 2));
      bus.cmp_label = (noise && (t == 1 || t == 2)) ? ~label[1:0] : label[1:0];

      if (t == 0) begin
        checks++;
        if (busy !== 1'b0 || result !== prev_result[1:0] || timeout !== prev_to) begin
          $display("FAIL %s idle_state: busy=%b result=%b timeout=%b want 0 %b %b",
                   name, busy, result, timeout, prev_result[1:0], prev_to);
        end else passed++;
      end
      if (t == 1) begin
        checks++;
        if (result !== 2'b11 || timeout !== 1'b0)
          $display("FAIL %s accept_clear: result=%b timeout=%b want 11 0", name, result, timeout);
        else passed++;
      end
      if (busy) busy_cnt++;
      if (bus.enc_clear) begin clear_cnt++; clear_t = t; end
      if (bus.enc_valid) begin
        if (stalled && bus.enc_char !== held) stab_err++;
        if (bus.enc_ready) begin
          if (hs < L) begin
            if (bus.enc_char !== saved[hs]) char_err++;
            if (bus.enc_last !== (hs == L - 1)) last_err++;
          end
          hs++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = bus.enc_char;
        end
      end
      if (bus.cmp_start) begin cs_cnt++; cs_t = t; end
      if (done) begin done_t = t; done_res = int'(result); done_to = timeout; end
    end
    start = 1'b0;
    bus.cmp_done = 1'b0;

    checks++;
    if (done_t !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, done_t, exp_lat);
    else passed++;
    checks++;
    if (done_res !== exp_res) $display("FAIL %s result: got %0d want %0d", name, done_res, exp_res);
    else passed++;
    checks++;
    if (done_to !== exp_to) $display("FAIL %s timeout: got %0d want %0d", name, done_to, exp_to);
    else passed++;
    checks++;
    if (hs !== L) $display("FAIL %s char_count: got %0d want %0d", name, hs, L);
    else passed++;
    checks++;
    if (char_err !== 0) $display("FAIL %s char_value: got %0d bad chars want 0", name, char_err);
    else passed++;
    checks++;
    if (last_err !== 0) $display("FAIL %s enc_last: got %0d bad flags want 0", name, last_err);
    else passed++;
    checks++;
    if (stab_err !== 0) $display("FAIL %s stall_stable: got %0d changes want 0", name, stab_err);
    else passed++;
    checks++;
    if (clear_cnt !== 1 || clear_t !== 1)
      $display("FAIL %s enc_clear: got %0d pulses at t=%0d want 1 at t=1", name, clear_cnt, clear_t);
    else passed++;
    checks++;
    if (cs_cnt !== ((L > 0) ? 1 : 0))
      $display("FAIL %s cmp_start_count: got %0d want %0d", name, cs_cnt, (L > 0) ? 1 : 0);
    else passed++;
    if (L > 0) begin
      checks++;
      if (cs_t !== 2 + E) $display("FAIL %s cmp_start_time: got %0d want %0d", name, cs_t, 2 + E);
      else passed++;
    end
    checks++;
    if (busy_cnt !== exp_lat) $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_lat);
    else passed++;

    prev_result = exp_res;
    prev_to     = exp_to;
  endtask

  task automatic load_hello;
    bytes[0] = 8'h68; bytes[1] = 8'h65; bytes[2] = 8'h6c; bytes[3] = 8'h6c; bytes[4] = 8'h6f;
  endtask

  task automatic randomize_bytes;
    for (int i = 0; i < ML; i++) bytes[i] = 8'($urandom);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 2'b11 || timeout !== 1'b0 ||
        bus.enc_clear !== 1'b0 || bus.enc_valid !== 1'b0 || bus.enc_last !== 1'b0 ||
        bus.enc_char !== 8'h00 || bus.cmp_start !== 1'b0)
      $display("FAIL reset_values: busy=%b done=%b result=%b timeout=%b clr=%b val=%b last=%b char=%h cs=%b",
               busy, done, result, timeout, bus.enc_clear, bus.enc_valid, bus.enc_last,
               bus.enc_char, bus.cmp_start);
    else passed++;
    reset = 1'b1;
    prev_result = 3;
    prev_to = 1'b0;
  endtask

  task automatic test_hello;
    randomize_bytes();
    load_hello();
    run_msg("hello", 5, 0, 0, 1, 1'b0);
  endtask

  task automatic test_stall;
    load_hello();
    run_msg("hello_stall", 5, 1, 0, 1, 1'b0);
  endtask

  task automatic test_empty;
    run_msg("empty", 0, 0, 0, 1, 1'b0);
  endtask

  task automatic test_overlength;
    randomize_bytes();
    run_msg("len250", 250, 0, 2, 0, 1'b0);
  endtask

  task automatic test_reset_mid;
    randomize_bytes();
    tick();
    set_msg(10);
    start = 1'b1;
    bus.enc_ready = 1'b1;
    bus.cmp_done = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      start = 1'b0;
    end
    checks++;
    if (bus.enc_valid !== 1'b1 || bus.enc_char !== bytes[3])
      $display("FAIL reset_mid_pre: valid=%b char=%h want 1 %h", bus.enc_valid, bus.enc_char, bytes[3]);
    else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 2'b11 || timeout !== 1'b0 ||
        bus.enc_clear !== 1'b0 || bus.enc_valid !== 1'b0 || bus.enc_last !== 1'b0 ||
        bus.enc_char !== 8'h00 || bus.cmp_start !== 1'b0)
      $display("FAIL reset_mid_values: busy=%b done=%b result=%b val=%b char=%h cs=%b",
               busy, done, result, bus.enc_valid, bus.enc_char, bus.cmp_start);
    else passed++;
    tick();
    tick();
    checks++;
    if (done !== 1'b0 || bus.cmp_start !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_mid_hold: done=%b cmp_start=%b busy=%b want 0 0 0", done, bus.cmp_start, busy);
    else passed++;
    reset = 1'b1;
    prev_result = 3;
    prev_to = 1'b0;
    randomize_bytes();
    run_msg("after_reset", 2, 0, 0, 2, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++) begin
      int len;
      randomize_bytes();
      len = (n % 4 == 0) ? int'($urandom_range(201, 255)) : int'($urandom_range(0, 40));
      run_msg("random", len, 2, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 3; n++) begin
      randomize_bytes();
      run_msg("back_to_back", int'($urandom_range(1, 8)), 0, 0, int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

`ifdef HDC_TIMEOUT_EN
  task automatic test_timeout;
    randomize_bytes();
    run_msg("timeout_never", 4, 0, -1, 1, 1'b0);
    run_msg("timeout_recover", 4, 0, 1, 1, 1'b0);
    run_msg("timeout_tie", 3, 0, int'(TO) - 1, 2, 1'b0);
    run_msg("timeout_late", 3, 2, int'(TO), 1, 1'b0);
    run_msg("timeout_clear", 6, 2, 0, 0, 1'b0);
  endtask
`endif

  initial begin
    bus.enc_ready = 1'b1;
    bus.cmp_done  = 1'b0;
    bus.cmp_label = 2'b00;
    test_reset();
    test_hello();
    test_stall();
    test_empty();
    test_overlength();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef HDC_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/hdc_classify_ctrl.md
# hdc_classify_ctrl

Sequencer for the hyperdimensional spam/ham classifier. It accepts one buffered message (up to MESSAGE_LENGTH characters) with its length and streams the characters one per cycle into the n-gram encoder under a valid/ready handshake. It then triggers the associative-memory similarity compare and returns the 2-bit class label with a done pulse. It sits between the message loader and the encoder/compare datapath in `main`.

## Interface
- MESSAGE_LENGTH, 200, max characters per message
- CHAR_LENGTH, 8, bits per character
- TIMEOUT, 1024, compare watchdog limit in cycles (used only with HDC_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request to classify msg/length; sampled only in IDLE
- msg  in  CHAR_LENGTH*MESSAGE_LENGTH  message buffer; char 0 = msg[CHAR_LENGTH*MESSAGE_LENGTH-1 -: CHAR_LENGTH] (MSB-first)
- length  in  8  character count of msg
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  2  00 ham, 01 spam, 11 inconclusive
- timeout  out  1  sticky until next accepted start; compare watchdog fired
- enc_clear  out  1  one-cycle pulse, clears encoder accumulator
- enc_char  out  CHAR_LENGTH  current character
- enc_valid  out  1  enc_char valid
- enc_last  out  1  qualifies final character
- enc_ready  in  1  encoder accepts char when enc_valid & enc_ready
- cmp_start  out  1  one-cycle pulse, start similarity compare
- cmp_done  in  1  compare complete, cmp_label valid this cycle
- cmp_label  in  2  compare result

## Operation
- States: IDLE, CLEAR, ENCODE, CMP, WAIT, DONE.
- IDLE: when start=1, msg and length are latched. Effective length L = min(length, MESSAGE_LENGTH). The FSM goes to CLEAR. start=1 in any other state is ignored.
- CLEAR: enc_clear=1 for one cycle. If L=0, go to DONE with result=11 and no cmp_start. Otherwise go to ENCODE with the char index at 0.
- ENCODE: enc_valid=1, enc_char=char[index], enc_last=(index==L-1).
  - On handshake the index increments.
  - On handshake with enc_last, go to CMP.
  - If enc_ready=0, enc_char, enc_valid and enc_last hold stable.
- CMP: cmp_start=1 for one cycle, then go to WAIT.
- WAIT: on cmp_done=1, capture cmp_label into result and go to DONE. A cmp_done in any other state is ignored.
- DONE: done=1 for one cycle, then go to IDLE. result holds until the next accepted start, which sets it to 11.
- Index counter width is clog2(MESSAGE_LENGTH+1). No wrap is possible because the index is bounded by L.
- Latched msg/length are immune to input changes while busy.

## Timing
- Reset values: busy=0, done=0, result=11, timeout=0, enc_clear=0, enc_valid=0, enc_last=0, enc_char=0, cmp_start=0. State=IDLE.
- Reset asserted mid-operation returns the FSM to IDLE immediately. No done pulse and no cmp_start are issued.
- All outputs are registered; no combinational path exists from inputs to outputs.
- With start accepted at edge k, enc_ready=1 throughout, and cmp_done returned in the first WAIT cycle:
  - CLEAR at cycle k+1
  - chars on cycles k+2..k+1+L
  - cmp_start at k+2+L
  - WAIT at k+3+L
  - done at k+4+L
  - Total latency is L+4 cycles.
- Each cycle with enc_ready=0 during ENCODE adds one cycle. Each cycle of WAIT without cmp_done adds one cycle.
- L=0: done arrives 2 cycles after accept (CLEAR, then DONE).
- Back-to-back operation: start sampled in the IDLE cycle right after DONE is accepted.

## Configuration
- HDC_TIMEOUT_EN defined: a watchdog counts WAIT cycles. If the count reaches TIMEOUT without cmp_done, the FSM goes to DONE with result=11 and timeout=1. A cmp_done that arrives in the same cycle as expiry wins: the label is captured and timeout stays 0.
- HDC_TIMEOUT_EN undefined: WAIT is unbounded and timeout is tied to 0.

## Test plan
- length=5, msg chars "hello", enc_ready=1, cmp_done with cmp_label=01 in the first WAIT cycle:
  - enc_char sequence is 68,65,6C,6C,6F, with enc_last on 6F.
  - One cmp_start, done at k+9, result=01.
- Same message with enc_ready toggling 1,0,1,0…: characters are never dropped or duplicated, enc_char is stable while stalled, and done comes 4 cycles later than with enc_ready=1.
- length=0: enc_clear pulse, no enc_valid, no cmp_start, done at k+2, result=11.
- length=250: exactly 200 characters are streamed, and enc_last is on char 199.
- reset deasserted low (asserted) during ENCODE at index 3, then start with length=2: all outputs return to reset values immediately, and a fresh full sequence of 2 chars runs.
- With HDC_TIMEOUT_EN and TIMEOUT=16, cmp_done never asserted: done arrives 16 WAIT cycles after entering WAIT, with result=11 and timeout=1. A following successful run clears timeout to 0.
